// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encodings for the keypad and its supervisor
package keypad_pkg;

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        ACTIVE     = 2'd1,
        UNLOCKED   = 2'd2,
        LOCKED_OUT = 2'd3
    } sup_state_t;

    // Keypad FSM codes, kept here so the keypad and its supervisor agree on one encoding
    typedef enum logic [2:0] {
        KP_IDLE   = 3'd0,
        KP_DIG1   = 3'd1,
        KP_DIG2   = 3'd2,
        KP_DIG3   = 3'd3,
        KP_UNLOCK = 3'd4,
        KP_ALARM  = 3'd5
    } kp_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector
module btn_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    logic samp_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            samp_q <= level_i;
            prev_q <= samp_q;
        end
    end

    assign pulse_o = samp_q & ~prev_q;

endmodule

// File: rtl/keypad_supervisor.sv
// rtl/keypad_supervisor.sv - button pulsing, failure counting, lockout and relock timing for keypad
module keypad_supervisor
    import keypad_pkg::*;
#(
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int UNLOCK_CYC  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enbl_i,
    input  logic                          zraw_i,
    input  logic                          oraw_i,
    input  logic                          rsto_i,
    input  logic                          ulck_i,
    input  logic                          secv_i,
    output logic                          zbut_o,
    output logic                          obut_o,
    output logic                          seci_o,
    output logic                          kpen_o,
    output logic                          lockout_o,
    output logic                          alarm_o,
    output logic [$clog2(MAX_FAIL+1)-1:0] failcnt_o
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(max_int(LOCKOUT_CYC, UNLOCK_CYC) + 1);

    logic z_rise, o_rise, rsto_rise, ulck_rise;

    btn_edge u_z    (.clk_i(clk_i), .rst_i(rst_i), .level_i(zraw_i), .pulse_o(z_rise));
    btn_edge u_o    (.clk_i(clk_i), .rst_i(rst_i), .level_i(oraw_i), .pulse_o(o_rise));
    btn_edge u_rsto (.clk_i(clk_i), .rst_i(rst_i), .level_i(rsto_i), .pulse_o(rsto_rise));
    btn_edge u_ulck (.clk_i(clk_i), .rst_i(rst_i), .level_i(ulck_i), .pulse_o(ulck_rise));

    sup_state_t    state_q, state_d;
    logic [FW-1:0] failcnt_q, failcnt_d, failcnt_inc;
    logic [TW-1:0] timer_q, timer_d;
    logic          alarm_q, alarm_d;
    logic          zbut_q, zbut_d, obut_q, obut_d, seci_q, seci_d;
    logic          kpen_q, kpen_d, lockout_q, lockout_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= OFF;
            failcnt_q <= '0;
            timer_q   <= '0;
            alarm_q   <= 1'b0;
            zbut_q    <= 1'b0;
            obut_q    <= 1'b0;
            seci_q    <= 1'b0;
            kpen_q    <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            failcnt_q <= failcnt_d;
            timer_q   <= timer_d;
            alarm_q   <= alarm_d;
            zbut_q    <= zbut_d;
            obut_q    <= obut_d;
            seci_q    <= seci_d;
            kpen_q    <= kpen_d;
            lockout_q <= lockout_d;
        end
    end

    assign failcnt_inc = (failcnt_q == FW'(MAX_FAIL)) ? failcnt_q : failcnt_q + FW'(1);

    always_comb begin
        state_d   = state_q;
        failcnt_d = failcnt_q;
        timer_d   = timer_q;
        alarm_d   = alarm_q | (secv_i && (state_q != OFF));
        zbut_d    = 1'b0;
        obut_d    = 1'b0;
        seci_d    = 1'b0;
        if (!enbl_i) begin
            state_d   = OFF;
            failcnt_d = '0;
            timer_d   = '0;
            alarm_d   = 1'b0;
        end else begin
            case (state_q)
                OFF: state_d = ACTIVE;
                ACTIVE: begin
                    if (ulck_rise) begin
                        state_d   = UNLOCKED;
                        failcnt_d = '0;
                        timer_d   = TW'(UNLOCK_CYC);
                    end else if (rsto_rise) begin
                        failcnt_d = failcnt_inc;
                        if (failcnt_inc == FW'(MAX_FAIL)) begin
                            state_d = LOCKED_OUT;
                            timer_d = TW'(LOCKOUT_CYC);
                            seci_d  = 1'b1;
                        end
                    end else begin
                        zbut_d = z_rise & ~o_rise;
                        obut_d = o_rise & ~z_rise;
                    end
                end
                UNLOCKED: begin
                    // Leaving on the count of 1 makes the state last exactly the loaded cycles
                    if (timer_q <= TW'(1)) begin
                        timer_d = '0;
                        state_d = ACTIVE;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                LOCKED_OUT: begin
                    if (timer_q <= TW'(1)) begin
                        timer_d   = '0;
                        state_d   = ACTIVE;
                        failcnt_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: state_d = OFF;
            endcase
        end
        kpen_d    = (state_d != OFF);
        lockout_d = (state_d == LOCKED_OUT);
    end

    assign zbut_o    = zbut_q;
    assign obut_o    = obut_q;
    assign seci_o    = seci_q;
    assign kpen_o    = kpen_q;
    assign lockout_o = lockout_q;
    assign alarm_o   = alarm_q;
    assign failcnt_o = failcnt_q;

endmodule
